vga_display: RTL and testbench

- VGA 640x480@60 Hz timing generator, driven by a 25 MHz pixel clock (40 ns period).
- Produces hsync/vsync, a display-active flag, a once-per-frame strobe and the current pixel coordinates.
- Sits between the clock/reset block and the pixel/character renderer, which uses x/y/isDispRGB to drive RGB.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_axis_counter.sv | 57 +++++
 rtl/vga_display.sv | 78 +++++++
 tb/tb_vga_display.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 Hz timing constants and the sync-polarity helper
// used by the display timing generator.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam logic        SYNC_ACTIVE = 1'b0;

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int unsigned COORD_W = 10;

    // Drive the asserted polarity inside the sync window, its inverse elsewhere.
    function automatic logic sync_level(input logic in_window, input logic polarity);
        if (in_window) begin
            return polarity;
        end else begin
            return ~polarity;
        end
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the raster: modulo counter with advance enable, wrap flag,
// and decodes for the active region and the sync window.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned ACTIVE     = 640,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_END   = 751
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               advance,
    output logic [COORD_W-1:0] cnt,
    output logic               wrap,
    output logic               active,
    output logic               in_sync
);

    localparam logic [COORD_W-1:0] LAST_C   = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] ACTIVE_C = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] SS_C     = COORD_W'(SYNC_START);
    localparam logic [COORD_W-1:0] SE_C     = COORD_W'(SYNC_END);

    logic [COORD_W-1:0] cnt_r;
    logic               at_last_s;

    // Terminal-count and region decodes of the current count.
    always_comb begin
        at_last_s = (cnt_r == LAST_C);
        active    = (cnt_r < ACTIVE_C);
        in_sync   = (cnt_r >= SS_C) && (cnt_r <= SE_C);
        if (advance && at_last_s) begin
            wrap = 1'b1;
        end else begin
            wrap = 1'b0;
        end
    end

    // Modulo-TOTAL counter, stepping only when advance is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {COORD_W{1'b0}};
        end else if (advance) begin
            if (at_last_s) begin
                cnt_r <= {COORD_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(COORD_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/vga_display.sv
// VGA raster timing generator: chains a pixel and a line counter, masks
// coordinates to the visible window and strobes once per frame.
module vga_display #(
    parameter int unsigned H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP        = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP        = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP        = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP        = vga_timing_pkg::V_BP,
    parameter logic        SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
    input  logic                               clk_25mhz,
    input  logic                               rst_n,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               isDispRGB,
    output logic                               dispPulse,
    output logic [vga_timing_pkg::COORD_W-1:0] x,
    output logic [vga_timing_pkg::COORD_W-1:0] y
);

    import vga_timing_pkg::*;

    localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [COORD_W-1:0] h_cnt_s, v_cnt_s;
    logic h_wrap_s, v_wrap_s, h_active_s, v_active_s, h_sync_s, v_sync_s;
    logic disp_pulse_r;

    vga_axis_counter #(
        .TOTAL(HT), .ACTIVE(H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC - 1)
    ) u_h_axis (
        .clk(clk_25mhz), .rst_n(rst_n), .advance(1'b1),
        .cnt(h_cnt_s), .wrap(h_wrap_s), .active(h_active_s), .in_sync(h_sync_s)
    );

    // Lines advance once per completed pixel row.
    vga_axis_counter #(
        .TOTAL(VT), .ACTIVE(V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC - 1)
    ) u_v_axis (
        .clk(clk_25mhz), .rst_n(rst_n), .advance(h_wrap_s),
        .cnt(v_cnt_s), .wrap(v_wrap_s), .active(v_active_s), .in_sync(v_sync_s)
    );

    // Frame strobe lands on the edge where both axes return to zero.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            disp_pulse_r <= 1'b0;
        end else begin
            disp_pulse_r <= h_wrap_s && v_wrap_s;
        end
    end

    // Same-cycle decodes of the counter registers.
    always_comb begin
        hsync     = sync_level(h_sync_s, SYNC_ACTIVE);
        vsync     = sync_level(v_sync_s, SYNC_ACTIVE);
        isDispRGB = h_active_s && v_active_s;
        if (h_active_s) begin
            x = h_cnt_s;
        end else begin
            x = {COORD_W{1'b0}};
        end
        if (v_active_s) begin
            y = v_cnt_s;
        end else begin
            y = {COORD_W{1'b0}};
        end
    end

    assign dispPulse = disp_pulse_r;

endmodule

// File: tb/tb_vga_display.sv
// Self-checking bench: a full-size instance for line timing and a reduced-timing
// instance for frame-level behaviour, both compared every cycle against a raster model.
module tb_vga_display;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    logic a_hs, a_vs, a_de, a_pl;
    logic [9:0] a_x, a_y;
    logic b_hs, b_vs, b_de, b_pl;
    logic [9:0] b_x, b_y;

    int checks = 0;
    int errors = 0;
    int t_a = 0;
    int t_b = 0;

    int vis_b = 0;
    int vs_low_b = 0;
    int vs_first_b = -1;
    int pulse_q[$];

    always #20 clk = ~clk;

    vga_display dut_a (
        .clk_25mhz(clk), .rst_n(rst_a), .hsync(a_hs), .vsync(a_vs),
        .isDispRGB(a_de), .dispPulse(a_pl), .x(a_x), .y(a_y)
    );

    vga_display #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0)
    ) dut_b (
        .clk_25mhz(clk), .rst_n(rst_b), .hsync(b_hs), .vsync(b_vs),
        .isDispRGB(b_de), .dispPulse(b_pl), .x(b_x), .y(b_y)
    );

    // Clocks elapsed since each reset release.
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) t_a <= 0;
        else        t_a <= t_a + 1;
    end
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) t_b <= 0;
        else        t_b <= t_b + 1;
    end

    function automatic void model(input int t, input int ha, input int hf, input int hs_w,
                                  input int hb, input int va, input int vf, input int vs_w,
                                  input int vb, output logic hs, output logic vs,
                                  output logic de, output logic pl, output int ex, output int ey);
        int ht, vt, h, v;
        ht = ha + hf + hs_w + hb;
        vt = va + vf + vs_w + vb;
        h  = t % ht;
        v  = (t / ht) % vt;
        hs = !((h >= ha + hf) && (h < ha + hf + hs_w));
        vs = !((v >= va + vf) && (v < va + vf + vs_w));
        de = (h < ha) && (v < va);
        pl = (t != 0) && ((t % (ht * vt)) == 0);
        ex = (h < ha) ? h : 0;
        ey = (v < va) ? v : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t_a=%0d t_b=%0d)", name, act, exp, t_a, t_b);
        end
    endtask

    // Every-cycle comparison of both instances against the raster model.
    always @(negedge clk) begin
        logic hs, vs, de, pl;
        int ex, ey;
        model(t_a, 640, 16, 96, 48, 480, 10, 2, 33, hs, vs, de, pl, ex, ey);
        check("a_hsync", {31'd0, a_hs}, {31'd0, hs});
        check("a_vsync", {31'd0, a_vs}, {31'd0, vs});
        check("a_disp",  {31'd0, a_de}, {31'd0, de});
        check("a_pulse", {31'd0, a_pl}, {31'd0, pl});
        check("a_x", {22'd0, a_x}, ex);
        check("a_y", {22'd0, a_y}, ey);
        model(t_b, 8, 2, 3, 2, 6, 1, 2, 1, hs, vs, de, pl, ex, ey);
        check("b_hsync", {31'd0, b_hs}, {31'd0, hs});
        check("b_vsync", {31'd0, b_vs}, {31'd0, vs});
        check("b_disp",  {31'd0, b_de}, {31'd0, de});
        check("b_pulse", {31'd0, b_pl}, {31'd0, pl});
        check("b_x", {22'd0, b_x}, ex);
        check("b_y", {22'd0, b_y}, ey);
        if (rst_b && t_b < 150) begin
            vis_b += (b_de === 1'b1) ? 1 : 0;
            if (b_vs === 1'b0) begin
                vs_low_b++;
                if (vs_first_b < 0) vs_first_b = t_b;
            end
        end
        if (rst_b && b_pl === 1'b1) pulse_q.push_back(t_b);
    end

    task automatic wait_t(input bit sel_b, input int target);
        int n = 0;
        int cur;
        cur = sel_b ? t_b : t_a;
        while (cur != target && n < 20000) begin
            @(negedge clk);
            n++;
            cur = sel_b ? t_b : t_a;
        end
        if (cur != target) check("wait_timeout", cur, target);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_hsync"}, {31'd0, a_hs}, 32'd1);
        check({tag, "_vsync"}, {31'd0, a_vs}, 32'd1);
        check({tag, "_disp"},  {31'd0, a_de}, 32'd1);
        check({tag, "_pulse"}, {31'd0, a_pl}, 32'd0);
        check({tag, "_x"}, {22'd0, a_x}, 32'd0);
        check({tag, "_y"}, {22'd0, a_y}, 32'd0);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check_reset_a("rst");

        // Full-size line timing from the release edge.
        #9 rst_a = 1'b1;
        @(negedge clk);
        wait_t(1'b0, 639);  check("x_last", {22'd0, a_x}, 32'd639);
                            check("de_last", {31'd0, a_de}, 32'd1);
        wait_t(1'b0, 640);  check("de_off", {31'd0, a_de}, 32'd0);
                            check("x_off", {22'd0, a_x}, 32'd0);
        wait_t(1'b0, 655);  check("hs_before", {31'd0, a_hs}, 32'd1);
        wait_t(1'b0, 656);  check("hs_fall", {31'd0, a_hs}, 32'd0);
        wait_t(1'b0, 751);  check("hs_end", {31'd0, a_hs}, 32'd0);
        wait_t(1'b0, 752);  check("hs_rise", {31'd0, a_hs}, 32'd1);
        wait_t(1'b0, 805);  check("line1_x", {22'd0, a_x}, 32'd5);
                            check("line1_y", {22'd0, a_y}, 32'd1);
        wait_t(1'b0, 1455); check("hs2_before", {31'd0, a_hs}, 32'd1);
        wait_t(1'b0, 1456); check("hs2_fall", {31'd0, a_hs}, 32'd0);

        // Mid-frame asynchronous reset at line 2, pixel 300.
        wait_t(1'b0, 1900);
        check("mid_x", {22'd0, a_x}, 32'd300);
        @(posedge clk);
        #10 rst_a = 1'b0;
        #1 check_reset_a("async");
        repeat (3) @(posedge clk);
        #10 rst_a = 1'b1;
        @(negedge clk);
        wait_t(1'b0, 655);  check("re_hs_before", {31'd0, a_hs}, 32'd1);
        wait_t(1'b0, 656);  check("re_hs_fall", {31'd0, a_hs}, 32'd0);

        // Reduced-timing frame behaviour (15 x 10 raster, 150-clock frames).
        @(posedge clk);
        #10 rst_b = 1'b1;
        @(negedge clk);
        wait_t(1'b1, 150);
        check("b_pulse1", {31'd0, b_pl}, 32'd1);
        check("b_pulse1_x", {22'd0, b_x}, 32'd0);
        check("b_pulse1_y", {22'd0, b_y}, 32'd0);
        wait_t(1'b1, 460);
        check("b_visible", vis_b, 32'd48);
        check("b_vs_low", vs_low_b, 32'd30);
        check("b_vs_first", vs_first_b, 32'd105);
        check("b_npulse", pulse_q.size(), 32'd3);
        if (pulse_q.size() == 3) begin
            check("b_pulse_t0", pulse_q[0], 32'd150);
            check("b_pulse_t1", pulse_q[1], 32'd300);
            check("b_pulse_t2", pulse_q[2], 32'd450);
        end

        // Reduced-timing mid-frame reset at line 4, pixel 10 of a frame.
        wait_t(1'b1, 520);
        @(posedge clk);
        #10 rst_b = 1'b0;
        #1 check("b_async_y", {22'd0, b_y}, 32'd0);
        repeat (3) @(posedge clk);
        #10 rst_b = 1'b1;
        @(negedge clk);
        wait_t(1'b1, 149);  check("b_re_nopulse", {31'd0, b_pl}, 32'd0);
        wait_t(1'b1, 150);  check("b_re_pulse", {31'd0, b_pl}, 32'd1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
